// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: one memory request/response port, used for the two cache
// clients and for the shared main-memory side of the arbiter.
//   req_valid/req_ready            command handshake
//   req_addr, req_rw               beat address, 1=write 0=read
//   req_data_valid/req_data_ready  write-data handshake
//   req_data_bits, req_data_mask   write beat and byte mask
//   resp_valid, resp_data          read beat returned to the requester
// master drives requests (a cache, or the arbiter towards memory);
// slave accepts them (the arbiter towards a cache, or the memory).
interface mem_arbiter_if #(
  parameter int ADDR_BITS = 28,
  parameter int DATA_BITS = 128
) ();
  logic                   req_valid;
  logic                   req_ready;
  logic [ADDR_BITS-1:0]   req_addr;
  logic                   req_rw;
  logic                   req_data_valid;
  logic                   req_data_ready;
  logic [DATA_BITS-1:0]   req_data_bits;
  logic [DATA_BITS/8-1:0] req_data_mask;
  logic                   resp_valid;
  logic [DATA_BITS-1:0]   resp_data;

  modport master (
    output req_valid, req_addr, req_rw, req_data_valid, req_data_bits, req_data_mask,
    input  req_ready, req_data_ready, resp_valid, resp_data
  );

  modport slave (
    input  req_valid, req_addr, req_rw, req_data_valid, req_data_bits, req_data_mask,
    output req_ready, req_data_ready, resp_valid, resp_data
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: merges the instruction-cache and data-cache memory ports onto
// one main-memory port. Commands and write data pass through combinationally;
// a write whose two handshakes complete on different cycles locks the port to
// its owner until the second one completes. Read responses come back in order
// and are steered to the issuer using a small FIFO of client IDs (0=IC, 1=DC).
// Ports:
//   clk, reset   clock, synchronous active-high reset
//   ic, dc       client ports (slave side of mem_arbiter_if)
//   mem          main-memory port (master side of mem_arbiter_if)
//   resp_error   sticky flag: a read beat arrived with no outstanding read
module mem_arbiter #(
  parameter int ADDR_BITS = 28,
  parameter int DATA_BITS = 128,
  parameter int ID_DEPTH  = 8
) (
  input  logic          clk,
  input  logic          reset,
  mem_arbiter_if.slave  ic,
  mem_arbiter_if.slave  dc,
  mem_arbiter_if.master mem,
  output logic          resp_error
);

  localparam int PTR_BITS = $clog2(ID_DEPTH);

  typedef enum logic [1:0] {
    ARB   = 2'd0,
    WDATA = 2'd1,
    WCMD  = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic                   owner_q, owner_d;
  logic                   lastGrant_q, lastGrant_d;
  logic [ID_DEPTH-1:0]    idFifo_q;
  logic [PTR_BITS-1:0]    wrPtr_q, rdPtr_q;
  logic [PTR_BITS:0]      count_q, count_d;
  logic                   respError_q;

  logic                   icActive, dcActive, sel;
  logic                   selValid, selRw, selDataValid;
  logic [ADDR_BITS-1:0]   selAddr;
  logic [DATA_BITS-1:0]   selData;
  logic [DATA_BITS/8-1:0] selMask;
  logic                   cmdReady, dataReady, memValid, memDataValid;
  logic                   cmdFire, dataFire;
  logic                   fifoFull, fifoEmpty, push, pop, headId;

  assign fifoFull  = (count_q == (PTR_BITS+1)'(ID_DEPTH));
  assign fifoEmpty = (count_q == '0);

  // Client selection: the lock owner outside ARB; in ARB the only active
  // client, or on a tie the one that was not granted last.
  always_comb begin
    icActive = ic.req_valid | ic.req_data_valid;
    dcActive = dc.req_valid | dc.req_data_valid;
    if (state_q != ARB) begin
      sel = owner_q;
    end else if (icActive && dcActive) begin
      sel = ~lastGrant_q;
    end else begin
      sel = dcActive;
    end
    selValid     = sel ? dc.req_valid      : ic.req_valid;
    selRw        = sel ? dc.req_rw         : ic.req_rw;
    selDataValid = sel ? dc.req_data_valid : ic.req_data_valid;
    selAddr      = sel ? dc.req_addr       : ic.req_addr;
    selData      = sel ? dc.req_data_bits  : ic.req_data_bits;
    selMask      = sel ? dc.req_data_mask  : ic.req_data_mask;
  end

  // Channel gating and next-state for the write lock and grant history.
  always_comb begin
    cmdReady     = 1'b0;
    dataReady    = 1'b0;
    memValid     = 1'b0;
    memDataValid = 1'b0;
    cmdFire      = 1'b0;
    dataFire     = 1'b0;
    push         = 1'b0;
    state_d      = state_q;
    owner_d      = owner_q;
    lastGrant_d  = lastGrant_q;
    case (state_q)
      ARB: begin
        if (!selRw) begin
          // A read needs a free ID slot before the command can go out.
          memValid = selValid & ~fifoFull;
          cmdReady = mem.req_ready & ~fifoFull;
          push     = memValid & mem.req_ready;
          if (push) lastGrant_d = sel;
        end else begin
          memValid     = selValid;
          cmdReady     = mem.req_ready;
          memDataValid = selDataValid;
          dataReady    = mem.req_data_ready;
          cmdFire      = selValid & mem.req_ready;
          dataFire     = selDataValid & mem.req_data_ready;
          if (cmdFire && dataFire) begin
            lastGrant_d = sel;
          end else if (cmdFire) begin
            state_d = WDATA;
            owner_d = sel;
          end else if (dataFire) begin
            state_d = WCMD;
            owner_d = sel;
          end
        end
      end
      WDATA: begin
        memDataValid = selDataValid;
        dataReady    = mem.req_data_ready;
        if (selDataValid && mem.req_data_ready) begin
          state_d     = ARB;
          lastGrant_d = owner_q;
        end
      end
      WCMD: begin
        memValid = selValid;
        cmdReady = mem.req_ready;
        if (selValid && mem.req_ready) begin
          state_d     = ARB;
          lastGrant_d = owner_q;
        end
      end
      default: state_d = ARB;
    endcase
    if (reset) begin
      cmdReady     = 1'b0;
      dataReady    = 1'b0;
      memValid     = 1'b0;
      memDataValid = 1'b0;
      push         = 1'b0;
    end
  end

  // Forwarding: the unselected client always sees both readies low.
  assign mem.req_valid       = memValid;
  assign mem.req_data_valid  = memDataValid;
  assign mem.req_addr        = selAddr;
  assign mem.req_rw          = selRw;
  assign mem.req_data_bits   = selData;
  assign mem.req_data_mask   = selMask;
  assign ic.req_ready        = cmdReady & ~sel;
  assign dc.req_ready        = cmdReady & sel;
  assign ic.req_data_ready   = dataReady & ~sel;
  assign dc.req_data_ready   = dataReady & sel;

  // Response steering: the FIFO head names the client that issued the
  // oldest outstanding read; a beat with nothing outstanding is dropped.
  assign pop           = mem.resp_valid & ~fifoEmpty & ~reset;
  assign headId        = idFifo_q[rdPtr_q];
  assign ic.resp_valid = pop & ~headId;
  assign dc.resp_valid = pop & headId;
  assign ic.resp_data  = mem.resp_data;
  assign dc.resp_data  = mem.resp_data;
  assign resp_error    = respError_q;

  always_comb begin
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // State, grant history, ID FIFO and error flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ARB;
      owner_q     <= 1'b0;
      lastGrant_q <= 1'b0;
      wrPtr_q     <= '0;
      rdPtr_q     <= '0;
      count_q     <= '0;
      respError_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      lastGrant_q <= lastGrant_d;
      count_q     <= count_d;
      if (push) begin
        idFifo_q[wrPtr_q] <= sel;
        wrPtr_q           <= wrPtr_q + 1'b1;
      end
      if (pop) rdPtr_q <= rdPtr_q + 1'b1;
      if (mem.resp_valid && fifoEmpty) respError_q <= 1'b1;
    end
  end

endmodule
